// File: rtl/wb_dsp_equation_sequencer.sv
// wb_dsp_equation_sequencer
// Runs one DSP equation over a Wishbone master command port. It fetches a
// three-word descriptor (operand A address, operand B address, result address),
// reads both operands, applies the selected operation and writes the result back.
module wb_dsp_equation_sequencer #(
    parameter int dw = 32,
    parameter int aw = 32
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          start_equation,
    input  logic          stop_equation,
    input  logic [7:0]    equation,
    input  logic [aw-1:0] equation_address,
    input  logic          active,
    input  logic [dw-1:0] data_rd,
    output logic          start,
    output logic [aw-1:0] address,
    output logic [3:0]    selection,
    output logic          write,
    output logic [dw-1:0] data_wr,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [dw-1:0] result
);

    typedef enum logic [3:0] {
        S_IDLE, S_DESC0, S_DESC1, S_DESC2, S_RD_A, S_RD_B, S_EXEC, S_WR_RES, S_FINISH
    } state_t;

    typedef enum logic [1:0] {P_ISSUE, P_WAIT_HI, P_WAIT_LO} phase_t;

    state_t        state_reg, state_next;
    phase_t        phase_reg, phase_next;
    logic          start_eq_reg;
    logic [7:0]    op_reg, op_next;
    logic [aw-1:0] base_reg, base_next;
    logic [aw-1:0] addr_a_reg, addr_a_next;
    logic [aw-1:0] addr_b_reg, addr_b_next;
    logic [aw-1:0] addr_r_reg, addr_r_next;
    logic [dw-1:0] opa_reg, opa_next;
    logic [dw-1:0] opb_reg, opb_next;
    logic          start_reg, start_next;
    logic [aw-1:0] address_reg, address_next;
    logic [3:0]    selection_reg, selection_next;
    logic          write_reg, write_next;
    logic [dw-1:0] data_wr_reg, data_wr_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          error_reg, error_next;
    logic [dw-1:0] result_reg, result_next;

    // Command presented by the current transfer state
    logic [aw-1:0] xfer_addr;
    logic          xfer_write;
    logic [dw-1:0] xfer_data;

    // Select the address/direction/data of the transfer owned by the current state
    always_comb begin
        xfer_addr  = base_reg;
        xfer_write = 1'b0;
        xfer_data  = '0;
        case (state_reg)
            S_DESC1:  xfer_addr = base_reg + aw'(4);
            S_DESC2:  xfer_addr = base_reg + aw'(8);
            S_RD_A:   xfer_addr = addr_a_reg;
            S_RD_B:   xfer_addr = addr_b_reg;
            S_WR_RES: begin
                xfer_addr  = addr_r_reg;
                xfer_write = 1'b1;
                xfer_data  = result_reg;
            end
            default:  xfer_addr = base_reg;
        endcase
    end

    // Next-state and output logic: trigger, per-transfer handshake, execute, finish
    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        op_next        = op_reg;
        base_next      = base_reg;
        addr_a_next    = addr_a_reg;
        addr_b_next    = addr_b_reg;
        addr_r_next    = addr_r_reg;
        opa_next       = opa_reg;
        opb_next       = opb_reg;
        start_next     = 1'b0;
        address_next   = address_reg;
        selection_next = selection_reg;
        write_next     = write_reg;
        data_wr_next   = data_wr_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        error_next     = error_reg;
        result_next    = result_reg;

        case (state_reg)
            S_IDLE: begin
                // A held stop suppresses the edge entirely; error is left alone
                if (start_equation && !start_eq_reg && !stop_equation) begin
                    op_next    = equation;
                    base_next  = equation_address;
                    busy_next  = 1'b1;
                    error_next = 1'b0;
                    state_next = S_DESC0;
                    phase_next = P_ISSUE;
                end
            end
            S_EXEC: begin
                state_next = S_WR_RES;
                phase_next = P_ISSUE;
                case (op_reg)
                    8'd0:    result_next = opa_reg + opb_reg;
                    8'd1:    result_next = opa_reg - opb_reg;
                    8'd2:    result_next = opa_reg * opb_reg;
                    8'd3:    result_next = opa_reg & opb_reg;
                    8'd4:    result_next = opa_reg | opb_reg;
                    8'd5:    result_next = opa_reg ^ opb_reg;
                    default: begin
                        error_next = 1'b1;
                        state_next = S_FINISH;
                    end
                endcase
            end
            S_FINISH: begin
                busy_next  = 1'b0;
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                // Transfer states: abort is only honoured before a new issue
                case (phase_reg)
                    P_ISSUE: begin
                        if (stop_equation) begin
                            error_next = 1'b1;
                            state_next = S_FINISH;
                        end else if (!active) begin
                            start_next     = 1'b1;
                            address_next   = xfer_addr;
                            selection_next = 4'hF;
                            write_next     = xfer_write;
                            data_wr_next   = xfer_data;
                            phase_next     = P_WAIT_HI;
                        end
                    end
                    P_WAIT_HI: begin
                        if (active) phase_next = P_WAIT_LO;
                    end
                    default: begin
                        if (!active) begin
                            phase_next = P_ISSUE;
                            case (state_reg)
                                S_DESC0: begin addr_a_next = aw'(data_rd); state_next = S_DESC1;  end
                                S_DESC1: begin addr_b_next = aw'(data_rd); state_next = S_DESC2;  end
                                S_DESC2: begin addr_r_next = aw'(data_rd); state_next = S_RD_A;   end
                                S_RD_A:  begin opa_next    = data_rd;      state_next = S_RD_B;   end
                                S_RD_B:  begin opb_next    = data_rd;      state_next = S_EXEC;   end
                                S_WR_RES:                                   state_next = S_FINISH;
                                default:                                    state_next = S_IDLE;
                            endcase
                        end
                    end
                endcase
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_reg     <= S_IDLE;
            phase_reg     <= P_ISSUE;
            start_eq_reg  <= 1'b0;
            op_reg        <= '0;
            base_reg      <= '0;
            addr_a_reg    <= '0;
            addr_b_reg    <= '0;
            addr_r_reg    <= '0;
            opa_reg       <= '0;
            opb_reg       <= '0;
            start_reg     <= 1'b0;
            address_reg   <= '0;
            selection_reg <= '0;
            write_reg     <= 1'b0;
            data_wr_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            result_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            start_eq_reg  <= start_equation;
            op_reg        <= op_next;
            base_reg      <= base_next;
            addr_a_reg    <= addr_a_next;
            addr_b_reg    <= addr_b_next;
            addr_r_reg    <= addr_r_next;
            opa_reg       <= opa_next;
            opb_reg       <= opb_next;
            start_reg     <= start_next;
            address_reg   <= address_next;
            selection_reg <= selection_next;
            write_reg     <= write_next;
            data_wr_reg   <= data_wr_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
            result_reg    <= result_next;
        end
    end

    assign start     = start_reg;
    assign address   = address_reg;
    assign selection = selection_reg;
    assign write     = write_reg;
    assign data_wr   = data_wr_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign error     = error_reg;
    assign result    = result_reg;

endmodule

// File: tb/tb_wb_dsp_equation_sequencer.sv
// Testbench for wb_dsp_equation_sequencer: a behavioural Wishbone master with
// memory, and a scoreboard of expected transfers popped as the DUT issues them.
module tb_wb_dsp_equation_sequencer;

    localparam int LAT  = 2;   // cycles from start to active rising
    localparam int HOLD = 2;   // cycles active stays high

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic        start_equation = 1'b0;
    logic        stop_equation = 1'b0;
    logic [7:0]  equation = '0;
    logic [31:0] equation_address = '0;
    logic        active = 1'b0;
    logic [31:0] data_rd = '0;
    logic        start;
    logic [31:0] address;
    logic [3:0]  selection;
    logic        write;
    logic [31:0] data_wr;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] result;

    wb_dsp_equation_sequencer #(.dw(32), .aw(32)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .start_equation(start_equation), .stop_equation(stop_equation),
        .equation(equation), .equation_address(equation_address),
        .active(active), .data_rd(data_rd),
        .start(start), .address(address), .selection(selection), .write(write),
        .data_wr(data_wr), .busy(busy), .done(done), .error(error), .result(result)
    );

    initial forever #5 wb_clk = ~wb_clk;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_checks = 0;
    int          n_errors = 0;
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] exp_last = '0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            8'd0:    return a + b;
            8'd1:    return a - b;
            8'd2:    return a * b;
            8'd3:    return a & b;
            8'd4:    return a | b;
            8'd5:    return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    // Count done pulses
    always @(negedge wb_clk) if (done) done_cnt++;

    // Behavioural master: accept start, raise active after LAT, drop it after HOLD
    int          m_phase = 0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic        m_write = 1'b0;
    always @(negedge wb_clk) begin
        if (wb_rst) begin
            m_phase = 0;
            active  = 1'b0;
        end else begin
            if (start && m_phase != 0) check_value("start_while_active", 1, 0);
            case (m_phase)
                0: if (start) begin
                    xfer_t e;
                    xfer_cnt++;
                    m_addr  = address;
                    m_write = write;
                    m_data  = data_wr;
                    $display("xfer %0d: %s addr=0x%08h wdata=0x%08h", xfer_cnt,
                             write ? "WR" : "RD", address, data_wr);
                    check_value("xfer_sel", {60'd0, selection}, 64'hF);
                    if (exp_q.size() == 0) begin
                        check_value("xfer_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_value("xfer_addr", {32'd0, address}, {32'd0, e.a});
                        check_value("xfer_write", {63'd0, write}, {63'd0, e.w});
                        if (e.w) check_value("xfer_wdata", {32'd0, data_wr}, {32'd0, e.d});
                    end
                    m_cnt   = LAT;
                    m_phase = 1;
                end
                1: if (m_cnt <= 1) begin
                    active  = 1'b1;
                    m_cnt   = HOLD;
                    m_phase = 2;
                end else m_cnt--;
                default: if (m_cnt <= 1) begin
                    active = 1'b0;
                    if (m_write) mem[m_addr] = m_data;
                    else data_rd = mem_rd(m_addr);
                    m_phase = 0;
                end else m_cnt--;
            endcase
        end
    end

    task automatic wait_xfers(input int target);
        for (int k = 0; k < 500 && xfer_cnt < target; k++) begin
            @(negedge wb_clk);
            #1;
        end
        check_value("xfer_reached", {63'd0, xfer_cnt >= target}, 1);
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int k = 0; k < 1000 && done_cnt == d0; k++) @(negedge wb_clk);
        check_value({tag, "_done_seen"}, {63'd0, done_cnt != d0}, 1);
        repeat (3) @(negedge wb_clk);
        check_value({tag, "_done_once"}, 64'(done_cnt - d0), 1);
    endtask

    // mode 0: plain pulse, 1: hold start high across run, 2: extra edge mid-run
    task automatic run_equation(input string tag, input logic [7:0] op, input logic [31:0] base,
                                input logic [31:0] aa, input logic [31:0] ab, input logic [31:0] ar,
                                input logic [31:0] va, input logic [31:0] vb, input int mode);
        int          x0, d0;
        logic        legal;
        logic [31:0] exp_res;
        legal   = (op <= 8'd5);
        exp_res = legal ? model_op(op, va, vb) : exp_last;
        mem[base] = aa; mem[base + 32'd4] = ab; mem[base + 32'd8] = ar;
        mem[aa] = va; mem[ab] = vb;
        exp_q.push_back('{1'b0, base, 32'h0});
        exp_q.push_back('{1'b0, base + 32'd4, 32'h0});
        exp_q.push_back('{1'b0, base + 32'd8, 32'h0});
        exp_q.push_back('{1'b0, aa, 32'h0});
        exp_q.push_back('{1'b0, ab, 32'h0});
        if (legal) exp_q.push_back('{1'b1, ar, exp_res});
        x0 = xfer_cnt; d0 = done_cnt;
        equation = op; equation_address = base;
        @(negedge wb_clk); start_equation = 1'b1;
        @(negedge wb_clk); if (mode != 1) start_equation = 1'b0;
        check_value({tag, "_busy"}, {63'd0, busy}, 1);
        if (mode == 2) begin
            wait_xfers(x0 + 2);
            @(negedge wb_clk); start_equation = 1'b1;
            @(negedge wb_clk); start_equation = 1'b0;
        end
        wait_done(tag, d0);
        repeat (40) @(negedge wb_clk);
        start_equation = 1'b0;
        check_value({tag, "_xfers"}, 64'(xfer_cnt - x0), legal ? 64'd6 : 64'd5);
        check_value({tag, "_result"}, {32'd0, result}, {32'd0, exp_res});
        check_value({tag, "_error"}, {63'd0, error}, {63'd0, !legal});
        check_value({tag, "_busy_end"}, {63'd0, busy}, 0);
        check_value({tag, "_queue"}, 64'(exp_q.size()), 0);
        if (legal) check_value({tag, "_mem"}, {32'd0, mem_rd(ar)}, {32'd0, exp_res});
        exp_last = exp_res;
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_start"}, {63'd0, start}, 0);
        check_value({tag, "_address"}, {32'd0, address}, 0);
        check_value({tag, "_sel"}, {60'd0, selection}, 0);
        check_value({tag, "_write"}, {63'd0, write}, 0);
        check_value({tag, "_data_wr"}, {32'd0, data_wr}, 0);
        check_value({tag, "_busy"}, {63'd0, busy}, 0);
        check_value({tag, "_done"}, {63'd0, done}, 0);
        check_value({tag, "_error"}, {63'd0, error}, 0);
        check_value({tag, "_result"}, {32'd0, result}, 0);
    endtask

    initial begin
        int          x0, d0;
        logic [31:0] ra, rb;
        repeat (3) @(negedge wb_clk);
        check_all_zero("reset");
        wb_rst = 1'b0;
        repeat (2) @(negedge wb_clk);

        run_equation("add", 8'd0, 32'h100, 32'h200, 32'h204, 32'h208, 32'd5, 32'd7, 0);
        check_value("add_const", {32'd0, exp_last}, 64'd12);
        run_equation("mul", 8'd2, 32'h140, 32'h240, 32'h244, 32'h248, 32'h10000, 32'h10000, 0);
        run_equation("sub", 8'd1, 32'h180, 32'h280, 32'h284, 32'h288, 32'd0, 32'd1, 0);
        run_equation("illegal", 8'd9, 32'h1C0, 32'h2C0, 32'h2C4, 32'h2C8, 32'd3, 32'd4, 0);
        for (int i = 3; i <= 5; i++) begin
            ra = $urandom; rb = $urandom;
            run_equation("logic", 8'(i), 32'h500 + 32'(i * 16), 32'h600, 32'h604, 32'h608 + 32'(i * 4), ra, rb, 0);
        end
        run_equation("hold", 8'd0, 32'h700, 32'h710, 32'h714, 32'h718, 32'd10, 32'd20, 1);
        run_equation("toggle", 8'd0, 32'h720, 32'h730, 32'h734, 32'h738, 32'd3, 32'd4, 2);

        // Abort during the operand A transfer
        mem[32'h800] = 32'h900; mem[32'h804] = 32'h904; mem[32'h808] = 32'h908;
        mem[32'h900] = 32'd1; mem[32'h904] = 32'd2;
        exp_q.push_back('{1'b0, 32'h800, 32'h0});
        exp_q.push_back('{1'b0, 32'h804, 32'h0});
        exp_q.push_back('{1'b0, 32'h808, 32'h0});
        exp_q.push_back('{1'b0, 32'h900, 32'h0});
        x0 = xfer_cnt; d0 = done_cnt;
        equation = 8'd0; equation_address = 32'h800;
        @(negedge wb_clk); start_equation = 1'b1;
        @(negedge wb_clk); start_equation = 1'b0;
        wait_xfers(x0 + 4);
        stop_equation = 1'b1;
        wait_done("abort", d0);
        repeat (20) @(negedge wb_clk);
        stop_equation = 1'b0;
        check_value("abort_xfers", 64'(xfer_cnt - x0), 4);
        check_value("abort_error", {63'd0, error}, 1);
        check_value("abort_busy", {63'd0, busy}, 0);
        check_value("abort_result", {32'd0, result}, {32'd0, exp_last});
        check_value("abort_queue", 64'(exp_q.size()), 0);

        // Start edge while stop is high: nothing happens, error stays set
        x0 = xfer_cnt; d0 = done_cnt;
        stop_equation = 1'b1;
        @(negedge wb_clk); start_equation = 1'b1;
        @(negedge wb_clk); start_equation = 1'b0;
        repeat (30) @(negedge wb_clk);
        stop_equation = 1'b0;
        repeat (10) @(negedge wb_clk);
        check_value("stopstart_xfers", 64'(xfer_cnt - x0), 0);
        check_value("stopstart_done", 64'(done_cnt - d0), 0);
        check_value("stopstart_busy", {63'd0, busy}, 0);
        check_value("stopstart_error", {63'd0, error}, 1);

        // Asynchronous reset while waiting for active in the second descriptor read
        mem[32'hA00] = 32'hB00; mem[32'hA04] = 32'hB04; mem[32'hA08] = 32'hB08;
        exp_q.push_back('{1'b0, 32'hA00, 32'h0});
        exp_q.push_back('{1'b0, 32'hA04, 32'h0});
        x0 = xfer_cnt;
        equation = 8'd0; equation_address = 32'hA00;
        @(negedge wb_clk); start_equation = 1'b1;
        @(negedge wb_clk); start_equation = 1'b0;
        wait_xfers(x0 + 2);
        #1 wb_rst = 1'b1;
        #1 check_all_zero("midreset");
        repeat (3) @(negedge wb_clk);
        wb_rst = 1'b0;
        exp_q.delete();
        exp_last = 32'h0;
        repeat (3) @(negedge wb_clk);
        check_value("postreset_xfers", 64'(xfer_cnt - x0), 2);

        // Clean run with descriptor addresses wrapping past the top of memory
        run_equation("wrap", 8'd0, 32'hFFFF_FFF8, 32'hC00, 32'hC04, 32'hC08, 32'd100, 32'd23, 0);
        check_value("wrap_desc2", {32'd0, mem_rd(32'h0)}, 64'hC08);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_dsp_equation_sequencer.md
Name: wb_dsp_equation_sequencer

Overview:
- Sequences one DSP equation over the single Wishbone master interface command port.
- Triggered by the control register: fetches a 3-word descriptor at the equation address, reads operands A and B, computes the selected operation and writes the result back.
- Sits between the slave register block (control/equation address in, status out) and the master interface (start/address/selection/write/data_wr out; active/data_rd in).

Parameters:
dw, 32, data width of the bus and the registers
aw, 32, address width

Ports:
wb_clk  input  1  clock
wb_rst  input  1  asynchronous, active-high reset
start_equation  input  1  control bit; a rising edge starts a run
stop_equation  input  1  control bit; level high requests an abort
equation  input  8  opcode, sampled at run start
equation_address  input  aw  descriptor base address, sampled at run start
active  input  1  master interface busy
data_rd  input  dw  master interface read data
start  output  1  one-cycle request to the master interface
address  output  aw  transfer address
selection  output  4  byte selects
write  output  1  1 = write transfer
data_wr  output  dw  write data
busy  output  1  run in progress
done  output  1  one-cycle pulse at run end
error  output  1  sticky: illegal opcode or abort
result  output  dw  last computed result

Behaviour:
- Reset (async, wb_rst=1): state IDLE. start=0, address=0, selection=0, write=0, data_wr=0, busy=0, done=0, error=0, result=0. All internal registers cleared.
- Master handshake: pulse start for exactly one cycle with address/selection/write/data_wr stable. Wait for active=1 (WAIT_HI), then active=0 (WAIT_LO). On the active=0 cycle, capture data_rd on reads. Command outputs hold their values until the next issue.
- selection=4'hF on every transfer.
- Start detect: register start_equation and trigger on 0->1 only while IDLE. Edges while busy are ignored.
- On trigger:
  - latch equation → op and equation_address → base.
  - busy=1; clear error.
- States and transfers: IDLE → DESC0 → DESC1 → DESC2 → RD_A → RD_B → EXEC → WR_RES → FINISH → IDLE. Each transfer state has ISSUE/WAIT_HI/WAIT_LO sub-phases.
  - DESC0: read base+0 → addr_a.
  - DESC1: read base+4 → addr_b.
  - DESC2: read base+8 → addr_r.
  - RD_A: read addr_a → opa.
  - RD_B: read addr_b → opb.
- EXEC (1 cycle): all arithmetic is modulo 2^dw, unsigned.
  - op 0: opa+opb
  - op 1: opa-opb
  - op 2: low dw bits of opa*opb
  - op 3: opa&opb
  - op 4: opa|opb
  - op 5: opa^opb
  - ops 6..255: error=1, skip WR_RES, go to FINISH; result is unchanged.
- WR_RES: write result to addr_r with write=1, data_wr=result.
- FINISH: busy=0, done=1 for one cycle, return to IDLE.
- Minimum run length: 6 transfers × (1 issue cycle + master latency) + EXEC + FINISH.
- Abort: stop_equation=1 while busy is sampled only at ISSUE boundaries. An in-flight transfer always completes its handshake and is never cut off. Then error=1, go to FINISH, no result write. If stop is set in IDLE, the run does not start while it remains high.
- Simultaneous start edge and stop=1: stop wins, no run starts, error is unchanged.
- Address arithmetic: base+4 and base+8 wrap modulo 2^aw.
- Reset mid-run: everything returns to reset values immediately. A master transaction already in flight is the master's responsibility.
- The sequencer never issues start while active=1.

Test Plan:
- ADD run: base=0x100, descriptor {0x200,0x204,0x208}, mem[0x200]=5, mem[0x204]=7, equation=0 → six transfers in order 0x100,0x104,0x108,0x200,0x204 (reads) then 0x208 (write); mem[0x208]=12, result=12, done pulses once, error=0.
- SUB/MUL wrap: A=0, B=1, op1 → result=0xFFFFFFFF; A=0x10000, B=0x10000, op2 → result=0.
- Illegal opcode 9 → five reads, no write, error=1, done pulses, result keeps its previous value.
- Abort: raise stop_equation during the RD_A wait → the RD_A transfer completes, RD_B is never issued, error=1, busy falls, done pulses.
- Start handling: hold start_equation high across two runs → only one run. Toggle it during busy → ignored. Start edge with stop=1 → no start pulse issued.
- Async reset during WAIT_HI of DESC1 → all outputs 0 within the reset assertion. A following clean start runs normally. Also check base=0xFFFFFFF8 → descriptor addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
